fifo_sync_flex: RTL

Parametrised synchronous FIFO, the next generation of the team's basic FIFO. It adds selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy output, write-while-full when a read is accepted in the same cycle, and sticky overflow/underflow error flags. It sits between producer/consumer blocks in a single clock domain.

---
 rtl/fifo_sync_flex.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fifo_sync_flex.sv
// fifo_sync_flex: single-clock FIFO with standard or first-word-fall-through
// read mode, programmable almost-full/almost-empty thresholds, an occupancy
// count, pass-through writes while full and sticky overflow/underflow flags.
// DEPTH need not be a power of two: the pointers wrap on an explicit compare.

module fifo_sync_flex #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int LW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    localparam int            PW        = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF    = LW'(AF_THRESH);
    localparam logic [LW-1:0] LVL_AE    = LW'(AE_THRESH);

    logic [WIDTH-1:0] mem_r [0:DEPTH-1];
    logic [PW-1:0]    wptr_r;
    logic [PW-1:0]    rptr_r;
    logic [LW-1:0]    level_r;
    logic [WIDTH-1:0] dout_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             full_s;
    logic             empty_s;
    logic             rd_ok_s;
    logic             wr_ok_s;
    logic [PW-1:0]    wptr_nxt_s;
    logic [PW-1:0]    rptr_nxt_s;
    logic [LW-1:0]    level_nxt_s;
    logic [WIDTH-1:0] head_s;

    // Status flags come only from the registered count, never from wr_en/rd_en.
    always_comb begin
        full_s  = (level_r == LVL_FULL);
        empty_s = (level_r == {LW{1'b0}});
    end

    // Accept decisions; a write while full is allowed when a read frees a slot.
    always_comb begin
        rd_ok_s = rd_en & ~empty_s;
        wr_ok_s = wr_en & (~full_s | rd_ok_s);
    end

    // Pointer wrap by explicit compare so any DEPTH works.
    always_comb begin
        if (wptr_r == PTR_LAST) begin
            wptr_nxt_s = {PW{1'b0}};
        end else begin
            wptr_nxt_s = wptr_r + PW'(1);
        end
        if (rptr_r == PTR_LAST) begin
            rptr_nxt_s = {PW{1'b0}};
        end else begin
            rptr_nxt_s = rptr_r + PW'(1);
        end
    end

    // Occupancy update: a simultaneous read and write leaves the count alone.
    always_comb begin
        case ({wr_ok_s, rd_ok_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wptr_r] <= din;
        end
    end

    // Pointers, count and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            level_r <= {LW{1'b0}};
            dout_r  <= {WIDTH{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wptr_r <= wptr_nxt_s;
            end
            if (rd_ok_s) begin
                rptr_r <= rptr_nxt_s;
                dout_r <= mem_r[rptr_r];
            end
            level_r <= level_nxt_s;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_en & ~wr_ok_s) begin
                overflow_r <= 1'b1;
            end else if (err_clr) begin
                overflow_r <= 1'b0;
            end
            if (rd_en & empty_s) begin
                underflow_r <= 1'b1;
            end else if (err_clr) begin
                underflow_r <= 1'b0;
            end
        end
    end

    // Read data: fall-through shows the head word, otherwise the read register.
    always_comb begin
        head_s = mem_r[rptr_r];
        if (FWFT != 0) begin
            if (empty_s) begin
                dout = {WIDTH{1'b0}};
            end else begin
                dout = head_s;
            end
        end else begin
            dout = dout_r;
        end
    end

    // Output decode from registered state.
    always_comb begin
        full         = full_s;
        empty        = empty_s;
        almost_full  = (level_r >= LVL_AF);
        almost_empty = (level_r <= LVL_AE);
        level        = level_r;
        overflow     = overflow_r;
        underflow    = underflow_r;
    end

endmodule
